// File: rtl/proc_io_ctrl.sv
// proc_io_ctrl: bridges proc_fx strobe IO to per-channel valid/ready streams.
// Read latency 0 (head of the 2-entry input FIFO is muxed straight out); writes land 1 cycle later.
// Backpressure: in_ready drops when a channel FIFO holds 2 words; output overwrite raises err_ovf.
//
// Ports:
//   clk, rst               - rising-edge clock, asynchronous active-low reset
//   proc_req_in/addr_in    - processor read strobe and input channel select; proc_io_in returns data
//   proc_out_en/addr_out   - processor write strobe and output channel select; proc_io_out is the word
//   in_data/valid/ready    - NUIOIN input streams, channel i at in_data[i*NUBITS +: NUBITS]
//   out_data/valid/ready   - NUIOOU output streams, channel j at out_data[j*NUBITS +: NUBITS]
//   clr_err                - synchronous clear of sticky flags (and counters)
//   err_udf, err_ovf       - sticky underflow / overflow flags
// Optional build macro PROC_IO_STATS_EN adds saturating counters udf_cnt / ovf_cnt (CNTW bits).
module proc_io_ctrl #(
    parameter int NUBITS = 16,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int CNTW   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       proc_req_in,
    input  logic [$clog2(NUIOIN)-1:0]  proc_addr_in,
    output logic [NUBITS-1:0]          proc_io_in,
    input  logic                       proc_out_en,
    input  logic [$clog2(NUIOOU)-1:0]  proc_addr_out,
    input  logic [NUBITS-1:0]          proc_io_out,
    input  logic [NUIOIN*NUBITS-1:0]   in_data,
    input  logic [NUIOIN-1:0]          in_valid,
    output logic [NUIOIN-1:0]          in_ready,
    output logic [NUIOOU*NUBITS-1:0]   out_data,
    output logic [NUIOOU-1:0]          out_valid,
    input  logic [NUIOOU-1:0]          out_ready,
    input  logic                       clr_err,
    output logic                       err_udf,
    output logic                       err_ovf
`ifdef PROC_IO_STATS_EN
    ,
    output logic [CNTW-1:0]            udf_cnt,
    output logic [CNTW-1:0]            ovf_cnt
`endif
);

    // Input FIFO state: r_head is the word the processor sees next, r_tail the second slot.
    logic [1:0]        r_cnt  [NUIOIN];
    logic [NUBITS-1:0] r_head [NUIOIN];
    logic [NUBITS-1:0] r_tail [NUIOIN];
    logic [NUBITS-1:0] r_hold [NUIOIN];  // last word popped from each channel
    logic [NUBITS-1:0] r_last;           // last word popped from any channel (idle read value)

    logic [NUBITS-1:0] r_out_dat [NUIOOU];
    logic [NUIOOU-1:0] r_out_vld;
    logic              r_udf;
    logic              r_ovf;

    logic [NUIOIN-1:0] w_push;
    logic [NUIOIN-1:0] w_pop;
    logic [NUIOOU-1:0] w_wr;
    logic [NUBITS-1:0] w_rd_dat;
    logic              w_udf_evt;
    logic              w_ovf_evt;

    // Push/pop decode per input channel and write decode per output channel.
    always_comb begin
        w_push   = '0;
        w_pop    = '0;
        in_ready = '0;
        for (int i = 0; i < NUIOIN; i++) begin
            in_ready[i] = (r_cnt[i] != 2'd2);
            w_push[i]   = in_valid[i] && (r_cnt[i] != 2'd2);
            w_pop[i]    = proc_req_in && (int'(proc_addr_in) == i) && (r_cnt[i] != 2'd0);
        end
        w_wr = '0;
        for (int j = 0; j < NUIOOU; j++) begin
            w_wr[j] = proc_out_en && (int'(proc_addr_out) == j);
        end
    end

    // Read mux. An empty channel returns its own hold register and flags underflow;
    // a word being pushed into that channel this cycle is deliberately not forwarded.
    always_comb begin
        w_rd_dat  = r_last;
        w_udf_evt = 1'b0;
        if (proc_req_in) begin
            if (int'(proc_addr_in) < NUIOIN) begin
                if (r_cnt[proc_addr_in] != 2'd0) begin
                    w_rd_dat = r_head[proc_addr_in];
                end else begin
                    w_rd_dat  = r_hold[proc_addr_in];
                    w_udf_evt = 1'b1;
                end
            end else begin
                w_rd_dat = '0;
            end
        end
    end

    assign proc_io_in = w_rd_dat;

    // Only one output channel can be written per cycle, so at most one overflow event.
    assign w_ovf_evt = |(w_wr & r_out_vld & ~out_ready);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUIOIN; i++) begin
                r_cnt[i]  <= 2'd0;
                r_head[i] <= '0;
                r_tail[i] <= '0;
                r_hold[i] <= '0;
            end
            r_last <= '0;
        end else begin
            for (int i = 0; i < NUIOIN; i++) begin
                if (w_pop[i]) begin
                    r_hold[i] <= r_head[i];
                    r_last    <= r_head[i];
                end
                case (r_cnt[i])
                    2'd0: begin
                        if (w_push[i]) begin
                            r_head[i] <= in_data[i*NUBITS +: NUBITS];
                            r_cnt[i]  <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (w_push[i] && w_pop[i]) begin
                            r_head[i] <= in_data[i*NUBITS +: NUBITS];
                        end else if (w_push[i]) begin
                            r_tail[i] <= in_data[i*NUBITS +: NUBITS];
                            r_cnt[i]  <= 2'd2;
                        end else if (w_pop[i]) begin
                            r_cnt[i]  <= 2'd0;
                        end
                    end
                    default: begin
                        // Full: in_ready is low, so only a pop can happen.
                        if (w_pop[i]) begin
                            r_head[i] <= r_tail[i];
                            r_cnt[i]  <= 2'd1;
                        end
                    end
                endcase
            end
        end
    end

    // Output holding registers: a write always wins over a same-cycle consume.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int j = 0; j < NUIOOU; j++) begin
                r_out_dat[j] <= '0;
            end
            r_out_vld <= '0;
        end else begin
            for (int j = 0; j < NUIOOU; j++) begin
                if (w_wr[j]) begin
                    r_out_dat[j] <= proc_io_out;
                    r_out_vld[j] <= 1'b1;
                end else if (r_out_vld[j] && out_ready[j]) begin
                    r_out_vld[j] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int j = 0; j < NUIOOU; j++) begin
            out_data[j*NUBITS +: NUBITS] = r_out_dat[j];
        end
    end

    assign out_valid = r_out_vld;

    // Sticky flags: an event in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_udf <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_udf <= w_udf_evt || (r_udf && !clr_err);
            r_ovf <= w_ovf_evt || (r_ovf && !clr_err);
        end
    end

    assign err_udf = r_udf;
    assign err_ovf = r_ovf;

`ifdef PROC_IO_STATS_EN
    logic [CNTW-1:0] r_udf_cnt;
    logic [CNTW-1:0] r_ovf_cnt;

    // Saturating event counters; clear with a coincident event restarts at 1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_udf_cnt <= '0;
            r_ovf_cnt <= '0;
        end else begin
            if (clr_err) begin
                r_udf_cnt <= w_udf_evt ? CNTW'(1) : '0;
                r_ovf_cnt <= w_ovf_evt ? CNTW'(1) : '0;
            end else begin
                if (w_udf_evt && (r_udf_cnt != '1)) r_udf_cnt <= r_udf_cnt + CNTW'(1);
                if (w_ovf_evt && (r_ovf_cnt != '1)) r_ovf_cnt <= r_ovf_cnt + CNTW'(1);
            end
        end
    end

    assign udf_cnt = r_udf_cnt;
    assign ovf_cnt = r_ovf_cnt;
`else
    // Counter width only matters when statistics are built in.
    logic [CNTW-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_proc_io_ctrl.sv
module tb_proc_io_ctrl;

    localparam int NUBITS = 16;
    localparam int NUIOIN = 8;
    localparam int NUIOOU = 8;
    localparam int CNTW   = 16;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      proc_req_in;
    logic [2:0]                proc_addr_in;
    logic [NUBITS-1:0]         proc_io_in;
    logic                      proc_out_en;
    logic [2:0]                proc_addr_out;
    logic [NUBITS-1:0]         proc_io_out;
    logic [NUIOIN*NUBITS-1:0]  in_data;
    logic [NUIOIN-1:0]         in_valid;
    logic [NUIOIN-1:0]         in_ready;
    logic [NUIOOU*NUBITS-1:0]  out_data;
    logic [NUIOOU-1:0]         out_valid;
    logic [NUIOOU-1:0]         out_ready;
    logic                      clr_err;
    logic                      err_udf;
    logic                      err_ovf;
`ifdef PROC_IO_STATS_EN
    logic [CNTW-1:0]           udf_cnt;
    logic [CNTW-1:0]           ovf_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    proc_io_ctrl #(.NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU), .CNTW(CNTW)) dut (
        .clk           (clk),
        .rst           (rst),
        .proc_req_in   (proc_req_in),
        .proc_addr_in  (proc_addr_in),
        .proc_io_in    (proc_io_in),
        .proc_out_en   (proc_out_en),
        .proc_addr_out (proc_addr_out),
        .proc_io_out   (proc_io_out),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .clr_err       (clr_err),
        .err_udf       (err_udf),
        .err_ovf       (err_ovf)
`ifdef PROC_IO_STATS_EN
        ,
        .udf_cnt       (udf_cnt),
        .ovf_cnt       (ovf_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int ch, input logic [15:0] v);
        in_data[ch*NUBITS +: NUBITS] = v;
        in_valid[ch] = 1'b1;
    endtask

    function automatic logic [15:0] out_word(input int ch);
        return out_data[ch*NUBITS +: NUBITS];
    endfunction

    initial begin
        rst           = 1'b0;
        proc_req_in   = 1'b0;
        proc_addr_in  = '0;
        proc_out_en   = 1'b0;
        proc_addr_out = '0;
        proc_io_out   = '0;
        in_data       = '0;
        in_valid      = '0;
        out_ready     = '0;
        clr_err       = 1'b0;

        // Reset state
        #3;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_io_in", 32'(proc_io_in), 32'h0);
        chk("rst_out_data", 32'(out_word(3)), 32'h0);
        chk("rst_err", {30'd0, err_udf, err_ovf}, 32'h0);
        #10 rst = 1'b1;
        tick();
        chk("rel_in_ready", 32'(in_ready), 32'hFF);

        // Push then read on ch2
        set_in(2, 16'h1234);
        tick();
        in_valid = '0;
        proc_req_in = 1'b1; proc_addr_in = 3'd2;
        #1 chk("t1_read", 32'(proc_io_in), 32'h1234);
        tick();
        proc_req_in = 1'b0;
        #1 chk("t1_idle_hold", 32'(proc_io_in), 32'h1234);
        chk("t1_no_udf", 32'(err_udf), 32'h0);
        chk("t1_ready2", 32'(in_ready[2]), 32'h1);

        // FIFO full on ch0
        set_in(0, 16'h0001);
        tick();
        set_in(0, 16'h0002);
        tick();
        in_valid = '0;
        chk("t2_full_ready", 32'(in_ready[0]), 32'h0);
        proc_req_in = 1'b1; proc_addr_in = 3'd0;
        #1 chk("t2_pop1", 32'(proc_io_in), 32'h0001);
        tick();
        chk("t2_ready_after_pop", 32'(in_ready[0]), 32'h1);
        chk("t2_pop2", 32'(proc_io_in), 32'h0002);
        tick();
        proc_req_in = 1'b0;
        #1 chk("t2_no_udf", 32'(err_udf), 32'h0);

        // Underflow on ch5 after popping 0x00AA from it
        set_in(5, 16'h00AA);
        tick();
        in_valid = '0;
        proc_req_in = 1'b1; proc_addr_in = 3'd5;
        #1 chk("t3_pop", 32'(proc_io_in), 32'h00AA);
        tick();
        chk("t3_udf_data", 32'(proc_io_in), 32'h00AA);
        chk("t3_udf_not_yet", 32'(err_udf), 32'h0);
        tick();
        proc_req_in = 1'b0;
        chk("t3_udf_set", 32'(err_udf), 32'h1);
`ifdef PROC_IO_STATS_EN
        chk("t3_udf_cnt", 32'(udf_cnt), 32'h1);
`endif
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t3_udf_clr", 32'(err_udf), 32'h0);
`ifdef PROC_IO_STATS_EN
        chk("t3_udf_cnt_clr", 32'(udf_cnt), 32'h0);
`endif

        // Simultaneous push and pop on ch1 at count 1
        set_in(1, 16'h0010);
        tick();
        set_in(1, 16'h0020);
        proc_req_in = 1'b1; proc_addr_in = 3'd1;
        #1 chk("t4_pop_old", 32'(proc_io_in), 32'h0010);
        tick();
        in_valid = '0;
        #1 chk("t4_new_head", 32'(proc_io_in), 32'h0020);
        chk("t4_ready1", 32'(in_ready[1]), 32'h1);
        tick();
        proc_req_in = 1'b0;
        #1 chk("t4_no_udf", 32'(err_udf), 32'h0);

        // Output overflow on ch3
        out_ready = '0;
        proc_out_en = 1'b1; proc_addr_out = 3'd3; proc_io_out = 16'h0100;
        tick();
        chk("t5_valid", 32'(out_valid[3]), 32'h1);
        chk("t5_data1", 32'(out_word(3)), 32'h0100);
        chk("t5_no_ovf_yet", 32'(err_ovf), 32'h0);
        proc_io_out = 16'h0200;
        tick();
        proc_out_en = 1'b0;
        chk("t5_data2", 32'(out_word(3)), 32'h0200);
        chk("t5_ovf", 32'(err_ovf), 32'h1);
`ifdef PROC_IO_STATS_EN
        chk("t5_ovf_cnt", 32'(ovf_cnt), 32'h1);
`endif
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("t5_ovf_clr", 32'(err_ovf), 32'h0);
        // Write while ready: consumed and replaced, not an overflow
        out_ready[3] = 1'b1;
        proc_out_en = 1'b1; proc_io_out = 16'h0300;
        tick();
        proc_out_en = 1'b0;
        chk("t5_write_wins_vld", 32'(out_valid[3]), 32'h1);
        chk("t5_write_wins_dat", 32'(out_word(3)), 32'h0300);
        chk("t5_no_ovf", 32'(err_ovf), 32'h0);
        tick();
        chk("t5_consumed", 32'(out_valid[3]), 32'h0);
        out_ready[3] = 1'b0;
        // Overflow coinciding with clr_err: flag ends up set
        proc_out_en = 1'b1; proc_io_out = 16'h0400;
        tick();
        proc_io_out = 16'h0500; clr_err = 1'b1;
        tick();
        proc_out_en = 1'b0; clr_err = 1'b0;
        chk("t5_ovf_beats_clr", 32'(err_ovf), 32'h1);
`ifdef PROC_IO_STATS_EN
        chk("t5_ovf_cnt_clr_evt", 32'(ovf_cnt), 32'h1);
`endif

        // Async reset mid-stream
        set_in(0, 16'h0A0A);
        tick();
        set_in(0, 16'h0B0B);
        proc_out_en = 1'b1; proc_addr_out = 3'd6; proc_io_out = 16'h0606;
        tick();
        in_valid = '0; proc_out_en = 1'b0;
        chk("t6_pre_full", 32'(in_ready[0]), 32'h0);
        chk("t6_pre_valid", 32'(out_valid), 32'h48);
        #2 rst = 1'b0;
        #1 chk("t6_valid_drop", 32'(out_valid), 32'h0);
        chk("t6_ovf_drop", 32'(err_ovf), 32'h0);
        #2 rst = 1'b1;
        tick();
        chk("t6_ready_all", 32'(in_ready), 32'hFF);
        proc_req_in = 1'b1; proc_addr_in = 3'd0;
        #1 chk("t6_fifo_discarded", 32'(proc_io_in), 32'h0);
        tick();
        proc_req_in = 1'b0;
        chk("t6_udf_after_rst", 32'(err_udf), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/proc_io_ctrl.md
Name: proc_io_ctrl

Overview:
- IO controller between one proc_fx instance and its external sample streams.
- Converts the processor's strobe-style IO (req_in/addr_in/io_in, out_en/addr_out/io_out) into per-channel valid/ready streams.
- Each input channel has a 2-entry FIFO; each output channel has a holding register.
- Flags underflow (processor reads an empty channel) and overflow (processor overwrites an unconsumed output).

Parameters:
- NUBITS, 16, data word width; matches the processor.
- NUIOIN, 8, number of input channels.
- NUIOOU, 8, number of output channels.
- CNTW, 16, width of the statistics counters (used only with PROC_IO_STATS_EN).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- proc_req_in  in  1  processor input-read strobe.
- proc_addr_in  in  $clog2(NUIOIN)  processor input channel select.
- proc_io_in  out  NUBITS  data returned to the processor.
- proc_out_en  in  1  processor output-write strobe.
- proc_addr_out  in  $clog2(NUIOOU)  processor output channel select.
- proc_io_out  in  NUBITS  processor output data.
- in_data  in  NUIOIN*NUBITS  external input words; channel i occupies bits [i*NUBITS +: NUBITS].
- in_valid  in  NUIOIN  per-channel input valid.
- in_ready  out  NUIOIN  per-channel input ready.
- out_data  out  NUIOOU*NUBITS  per-channel output words.
- out_valid  out  NUIOOU  per-channel output valid.
- out_ready  in  NUIOOU  per-channel output ready.
- clr_err  in  1  synchronous clear of the sticky error flags (and counters when compiled in).
- err_udf  out  1  sticky underflow flag.
- err_ovf  out  1  sticky overflow flag.

Behaviour:
- Reset (rst=0, async):
  - All FIFO counts 0.
  - in_ready all 1 once reset is released.
  - out_valid 0, out_data 0, proc_io_in 0.
  - err_udf and err_ovf 0; hold registers 0.
- Input FIFO, channel i:
  - States EMPTY(0) -> ONE(1) -> FULL(2).
  - in_ready[i] = (count != 2), combinational from registered count.
  - Push when in_valid[i] & in_ready[i].
- Pop condition:
  - Pop when proc_req_in & proc_addr_in==i & count!=0.
  - Push and pop in the same cycle at count 1 leaves count at 1; head becomes the pushed word.
  - At count 2 no push is possible.
- Read path:
  - Read is combinational, 0 latency: proc_io_in = head of the selected FIFO while proc_req_in=1.
  - Otherwise proc_io_in = hold register.
  - On every pop, the hold register is loaded with the popped word on the next edge.
- Underflow:
  - proc_req_in on an EMPTY channel: proc_io_in = that channel's hold register (last popped value, 0 after reset).
  - err_udf is set next cycle; no state change.
  - A word arriving in the same cycle is not forwarded.
- Address out of range:
  - proc_addr_in >= NUIOIN: proc_io_in = 0, no pop, no flag.
  - proc_addr_out >= NUIOOU: write ignored, no flag.
- Output channel j, write:
  - proc_out_en & proc_addr_out==j loads out_data[j] = proc_io_out at the next edge; out_valid[j]=1 from the next cycle (1-cycle latency).
  - out_valid[j] clears on out_valid[j] & out_ready[j] unless a new write occurs in the same cycle.
  - Write wins: data updates and valid stays 1.
- Overflow:
  - A write while out_valid[j]=1 & out_ready[j]=0 overwrites the data and sets err_ovf.
  - A write while out_valid[j]=1 & out_ready[j]=1 is not an overflow.
- Sticky flags:
  - clr_err=1 clears err_udf and err_ovf next cycle.
  - If an error event coincides with clr_err, the flag is set (event wins).
- Reset mid-operation: all FIFO contents are discarded; out_valid drops immediately (async).

Optional Feature:
- Macro: PROC_IO_STATS_EN.
- Defined: adds output ports udf_cnt and ovf_cnt, each CNTW bits.
  - Each counts its error events, saturating at all-ones.
  - Cleared by reset; clr_err zeroes them, and an event coinciding with clr_err yields a count of 1.
- Undefined: ports and counters are absent; flags only.

Test Plan:
- Reset then push: push 0x1234 on ch2 (in_valid[2] 1 cycle), then proc_req_in with addr 2 next cycle -> proc_io_in=0x1234 that cycle; count returns to 0; err_udf stays 0.
- FIFO full: push 0x0001 and 0x0002 on ch0 without reads -> in_ready[0]=0; reads return 0x0001 then 0x0002; in_ready[0]=1 after the first pop.
- Underflow: read ch5 when empty after previously popping 0x00AA -> proc_io_in=0x00AA; err_udf=1 next cycle; clr_err clears it; with the macro, udf_cnt=1 before the clear.
- Simultaneous push/pop: ch1 count=1 holding 0x0010; push 0x0020 and pop in the same cycle -> proc_io_in=0x0010, then count 1 with head 0x0020.
- Output overflow: write 0x0100 to out ch3 with out_ready[3]=0, then write 0x0200 -> out_data[3]=0x0200, err_ovf=1. Repeat with out_ready[3]=1 on the second write -> no overflow, out_valid[3] stays 1.
- Async reset mid-stream: assert rst low between edges with FIFOs full and outputs valid -> out_valid=0 immediately; all counts 0 and in_ready all 1 after release.
